// File: rtl/popacc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : popacc_pkg
// Brief    : Shared FSM state type and width helpers for popcount_accumulator.
// Revision : 1.0
// ============================================================================
package popacc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_MAX_BEATS = 64;

  // Beat counter has to hold MAX_BEATS itself, not just MAX_BEATS-1.
  function automatic int beats_width(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

  localparam int BEATS_WIDTH = beats_width(DEFAULT_MAX_BEATS);

  function automatic int contrib_width(input int chunk_bits);
    return $clog2(chunk_bits) + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pop_to_signed.sv
`default_nettype none
// ============================================================================
// Module   : pop_to_signed
// Brief    : Clamps a popcount to CHUNK_BITS and maps it to 2*p - CHUNK_BITS.
// Revision : 1.0
// ============================================================================
module pop_to_signed
  import popacc_pkg::*;
#(
  parameter int CHUNK_BITS = 32,
  parameter int POP_WIDTH  = 16,
  parameter int CW         = contrib_width(CHUNK_BITS)
) (
  input  logic [POP_WIDTH-1:0] pop_i,
  output logic signed [CW-1:0] contrib_o
);

  localparam int EXT_W = (POP_WIDTH > 30) ? POP_WIDTH + 2 : 32;

  logic [EXT_W-1:0]        pop_ext;
  logic [EXT_W-1:0]        pop_clamped;
  logic signed [EXT_W-1:0] diff;

  always_comb begin
    pop_ext     = EXT_W'(pop_i);
    pop_clamped = (pop_ext > EXT_W'(CHUNK_BITS)) ? EXT_W'(CHUNK_BITS) : pop_ext;
    diff        = $signed(pop_clamped << 1) - $signed(EXT_W'(CHUNK_BITS));
    contrib_o   = CW'(diff);
  end

endmodule
`default_nettype wire

// File: rtl/popcount_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : popcount_accumulator
// Brief    : Accumulates signed +/-1 dot-product contributions per popcount
//            beat; result presented via valid/ready. POPACC_SAT_EN selects
//            saturating instead of wrapping accumulation.
// Revision : 1.0
// ============================================================================
module popcount_accumulator
  import popacc_pkg::*;
#(
  parameter int CHUNK_BITS = 32,
  parameter int POP_WIDTH  = 16,
  parameter int ACC_WIDTH  = 24,
  parameter int MAX_BEATS  = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [POP_WIDTH-1:0]              in_pop,
  input  logic                              in_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [ACC_WIDTH-1:0]       out_acc,
  output logic [beats_width(MAX_BEATS)-1:0] out_beats,
  output logic                              out_ovf
);

  localparam int CW = contrib_width(CHUNK_BITS);
  localparam int BW = beats_width(MAX_BEATS);

  state_e                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, out_acc_q, out_acc_d;
  logic [BW-1:0]               beats_q, beats_d, out_beats_q, out_beats_d;
  logic                        ovf_q, ovf_d, out_ovf_q, out_ovf_d;

  logic signed [CW-1:0]        contrib;
  logic signed [ACC_WIDTH:0]   base_ext, sum;
  logic signed [ACC_WIDTH-1:0] sum_fit;
  logic [BW-1:0]               beats_inc;
  logic                        beat, sum_ovf, last_beat, ovf_next;

  pop_to_signed #(
    .CHUNK_BITS (CHUNK_BITS),
    .POP_WIDTH  (POP_WIDTH),
    .CW         (CW)
  ) u_pop_to_signed (
    .pop_i     (in_pop),
    .contrib_o (contrib)
  );

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign out_acc   = out_acc_q;
  assign out_beats = out_beats_q;
  assign out_ovf   = out_ovf_q;

  // An IDLE beat starts a fresh sum, so the running value only feeds in from ACCUM.
  always_comb begin
    beat      = in_valid && in_ready;
    base_ext  = (state_q == ACCUM) ? (ACC_WIDTH+1)'(acc_q) : '0;
    sum       = base_ext + (ACC_WIDTH+1)'(contrib);
    sum_ovf   = (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]);
`ifdef POPACC_SAT_EN
    if (sum_ovf) begin
      sum_fit = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                               : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      sum_fit = sum[ACC_WIDTH-1:0];
    end
`else
    sum_fit   = sum[ACC_WIDTH-1:0];
`endif
    beats_inc = (state_q == ACCUM) ? beats_q + BW'(1) : BW'(1);
    last_beat = in_last || (beats_inc == BW'(MAX_BEATS));
    ovf_next  = ((state_q == ACCUM) && ovf_q) || sum_ovf;
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    beats_d     = beats_q;
    ovf_d       = ovf_q;
    out_acc_d   = out_acc_q;
    out_beats_d = out_beats_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (beat) begin
          acc_d   = sum_fit;
          beats_d = beats_inc;
          ovf_d   = ovf_next;
          if (last_beat) begin
            state_d     = DONE;
            out_acc_d   = sum_fit;
            out_beats_d = beats_inc;
            out_ovf_d   = ovf_next;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      beats_q     <= '0;
      ovf_q       <= 1'b0;
      out_acc_q   <= '0;
      out_beats_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beats_q     <= beats_d;
      ovf_q       <= ovf_d;
      out_acc_q   <= out_acc_d;
      out_beats_q <= out_beats_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule
`default_nettype wire
